mc_datapath: RTL and testbench



---
 rtl/mc_datapath_pkg.sv | 94 +++++++++
 rtl/mc_alu.sv | 46 ++++
 rtl/mc_datapath.sv | 231 +++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_datapath_pkg.sv
// -----------------------------------------------------------------------------
// mc_datapath_pkg
// Shared definitions for the multi-cycle datapath:
//   - MIPS opcode / funct encodings of the supported instruction subset
//   - FSM state encodings (legacy-compatible constants plus a typed enum)
//   - ALU operation enum
//   - decode_t and decode_instr(): opcode/funct -> control bundle
// -----------------------------------------------------------------------------
package mc_datapath_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // FSM state encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_MEM    = S_MEM,
        ST_WB     = S_WB
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    // Control bundle derived from the latched instruction.
    typedef struct packed {
        logic    legal;
        alu_op_e op;
        logic    use_imm;     // ALU B operand is sext(imm) instead of rt
        logic    dest_rd;     // write destination is rd (else rt)
        logic    writes_reg;  // instruction ends with a register write in WB
        logic    is_lw;
        logic    is_sw;
    } decode_t;

    function automatic decode_t decode_instr(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        decode_t d;
        d       = '0;
        d.legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                d.writes_reg = 1'b1;
                d.dest_rd    = 1'b1;
                case (funct)
                    FN_ADD:  d.op = ALU_ADD;
                    FN_SUB:  d.op = ALU_SUB;
                    FN_AND:  d.op = ALU_AND;
                    FN_OR:   d.op = ALU_OR;
                    FN_SLT:  d.op = ALU_SLT;
                    default: d.legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                d.use_imm    = 1'b1;
                d.writes_reg = 1'b1;
            end
            OP_LW: begin
                d.use_imm    = 1'b1;
                d.writes_reg = 1'b1;
                d.is_lw      = 1'b1;
            end
            OP_SW: begin
                d.use_imm    = 1'b1;
                d.is_sw      = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_alu.sv
// -----------------------------------------------------------------------------
// mc_alu
// Combinational ALU for the multi-cycle datapath.
// Ports:
//   a, b    in  DATA_W : operands (a = rs, b = rt or sext(imm))
//   op      in  alu_op_e : ADD / SUB / AND / OR / SLT
//   result  out DATA_W : modulo-2^DATA_W result; SLT yields 1 or 0 (signed)
//   ovf     out 1      : signed overflow of ADD / SUB, 0 for other ops
// -----------------------------------------------------------------------------
module mc_alu
    import mc_datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam int MSB = DATA_W - 1;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = a + b;
                // Same-sign operands producing a different-sign sum.
                ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = a - b;
                // Different-sign operands where the sign of a is not kept.
                ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mc_datapath.sv
// -----------------------------------------------------------------------------
// mc_datapath
// Multi-cycle MIPS-subset core: register file, ALU, word-addressed data memory
// and an internal FSM (IDLE -> DECODE -> EXEC -> [MEM] -> [WB]) that decodes
// each accepted instruction itself.
//
// Optional feature: define MC_DATAPATH_OVF_TRAP_EN to trap signed overflow on
// add/sub/addi (register write suppressed, ovf flagged with done in WB).
// Without it, arithmetic wraps and ovf is tied to 0.
//
// Ports:
//   clk          in  1      : rising-edge clock
//   rst_n        in  1      : synchronous active-low reset
//   instruction  in  32     : MIPS-encoded instruction
//   instr_valid  in  1      : instruction is valid
//   instr_ready  out 1      : FSM is in IDLE and will accept
//   RD1 / RD2    out DATA_W : registered rs / rt operands
//   ALU_RESULT   out DATA_W : registered ALU output
//   RD           out DATA_W : registered memory read data
//   busy         out 1      : FSM not in IDLE
//   done         out 1      : one-cycle completion pulse
//   illegal      out 1      : qualifies done, unsupported opcode/funct
//   ovf          out 1      : qualifies done, trapped signed overflow
// -----------------------------------------------------------------------------
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_N     = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] ALU_RESULT,
    output logic [DATA_W-1:0] RD,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              ovf
);

    localparam int RIDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;
    localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rd_q,  rd_d;

    logic [DATA_W-1:0] rf_q [REG_N];
    logic [DATA_W-1:0] rf_d [REG_N];
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Decode of the latched instruction (held stable for the whole op)
    // ------------------------------------------------------------------
    decode_t           dec;
    logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_val, rt_val;

    assign dec     = decode_instr(instr_q[31:26], instr_q[5:0]);
    assign rs_idx  = instr_q[21 +: RIDX_W];
    assign rt_idx  = instr_q[16 +: RIDX_W];
    assign rd_idx  = instr_q[11 +: RIDX_W];
    assign wr_idx  = dec.dest_rd ? rd_idx : rt_idx;
    assign imm_ext = DATA_W'($signed(instr_q[15:0]));

    // Register 0 reads as zero regardless of storage contents.
    assign rs_val = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_val = (rt_idx == '0) ? '0 : rf_q[rt_idx];

    // ------------------------------------------------------------------
    // ALU and optional overflow trap
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;
    logic              wb_trap;

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (rd1_q),
        .b      (dec.use_imm ? imm_ext : rd2_q),
        .op     (dec.op),
        .result (alu_y),
        .ovf    (alu_ovf)
    );

`ifdef MC_DATAPATH_OVF_TRAP_EN
    logic ovf_q, ovf_d;
    logic trap_class;

    // Only add, sub and addi trap; lw/sw also use ALU_ADD for addressing.
    assign trap_class = dec.writes_reg && !dec.is_lw &&
                        ((dec.op == ALU_ADD) || (dec.op == ALU_SUB));

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_EXEC) ovf_d = alu_ovf && trap_class;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign wb_trap = (state_q == ST_WB) && ovf_q;
`else
    // The overflow flag has no consumer when trapping is disabled.
    logic unused_alu_ovf;
    assign unused_alu_ovf = alu_ovf;
    assign wb_trap        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Memory and register-file write controls
    // ------------------------------------------------------------------
    logic [MIDX_W-1:0] mem_idx;
    logic              mem_we;
    logic              rf_we;
    logic [DATA_W-1:0] wr_data;

    // Byte address -> word index; upper bits wrap modulo MEM_DEPTH.
    assign mem_idx = alu_q[MIDX_W+1:2];
    assign mem_we  = rst_n && (state_q == ST_MEM) && dec.is_sw;
    assign rf_we   = (state_q == ST_WB) && dec.writes_reg &&
                     (wr_idx != '0) && !wb_trap;
    assign wr_data = dec.is_lw ? rd_q : alu_q;

    always_comb begin
        for (int i = 0; i < REG_N; i++) rf_d[i] = rf_q[i];
        if (rf_we) rf_d[wr_idx] = wr_data;
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instruction;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rd1_d   = rs_val;
                rd2_d   = rt_val;
                state_d = dec.legal ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                alu_d   = alu_y;
                state_d = (dec.is_lw || dec.is_sw) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dec.is_lw) begin
                    rd_d    = mem_q[mem_idx];
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and a synchronous reset branch that takes priority over every update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < REG_N; i++) rf_q[i] <= rf_d[i];
        end
    end

    // NOTE: data memory has no reset so it maps onto RAM; reset only blocks the write via mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= rd2_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RD1         = rd1_q;
    assign RD2         = rd2_q;
    assign ALU_RESULT  = alu_q;
    assign RD          = rd_q;
    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    // Completion flags are masked by reset so an aborted instruction never reports.
    assign illegal     = rst_n && (state_q == ST_DECODE) && !dec.legal;
    assign done        = rst_n && (((state_q == ST_DECODE) && !dec.legal) ||
                                   ((state_q == ST_MEM) && dec.is_sw) ||
                                   (state_q == ST_WB));
    assign ovf         = rst_n && wb_trap;

endmodule

// File: tb/tb_mc_datapath.sv
// -----------------------------------------------------------------------------
// tb_mc_datapath
// Directed, self-checking bench for mc_datapath. Each issued instruction
// pushes its expected completion record to a scoreboard queue; the record is
// popped and compared when the DUT raises done. Outputs are sampled on the
// falling edge; inputs are driven on the falling edge.
// With MC_DATAPATH_OVF_TRAP_EN the DUT is built at DATA_W=16 and overflow
// traps are expected; otherwise DATA_W=32 and results wrap.
// -----------------------------------------------------------------------------
module tb_mc_datapath;

`ifdef MC_DATAPATH_OVF_TRAP_EN
    localparam int   DW   = 16;
    localparam logic TRAP = 1'b1;
`else
    localparam int   DW   = 32;
    localparam logic TRAP = 1'b0;
`endif

    localparam logic [2:0] M_OPS = 3'b001;
    localparam logic [2:0] M_ALU = 3'b010;
    localparam logic [2:0] M_RD  = 3'b100;

    logic          clk;
    logic          rst_n;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] RD1, RD2, ALU_RESULT, RD;
    logic          busy, done, illegal, ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         tag;
        int            lat;
        logic          ill;
        logic          ov;
        logic [2:0]    mask;
        logic [DW-1:0] e1, e2, ea, er;
    } exp_t;

    exp_t sb[$];

    mc_datapath #(.DATA_W(DW), .REG_N(32), .MEM_DEPTH(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .RD1         (RD1),
        .RD2         (RD2),
        .ALU_RESULT  (ALU_RESULT),
        .RD          (RD),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, then compare its completion against the
    // scoreboard record. With noise set, instr_valid stays high while busy
    // and instruction carries an addi $2,$0,99 that must not be accepted.
    task automatic issue(input string tag, input logic [31:0] ins, input int lat,
                         input logic ill, input logic ov, input logic [2:0] mask,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input logic [DW-1:0] ea, input logic [DW-1:0] er,
                         input logic noise = 1'b0);
        exp_t e;
        int   cyc;
        logic seen;
        sb.push_back('{tag, lat, ill, ov, mask, e1, e2, ea, er});
        @(negedge clk);
        cyc = 0;
        while (!instr_ready && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".ready"}, 64'(instr_ready), 64'd1);
        instruction = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        cyc = 1;
        check({tag, ".busy"}, {62'd0, busy, instr_ready}, 64'd2);
        if (noise) instruction = i_ins(6'h08, 5'd0, 5'd2, 16'd99);
        else       instr_valid = 1'b0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        seen        = done;
        instr_valid = 1'b0;
        e = sb.pop_front();
        check({e.tag, ".done_cycle"}, seen ? 64'(cyc) : 64'hFFFF, 64'(e.lat));
        check({e.tag, ".illegal"}, 64'(illegal), 64'(e.ill));
        check({e.tag, ".ovf"}, 64'(ovf), 64'(e.ov));
        if (e.mask[0]) begin
            check({e.tag, ".RD1"}, 64'(RD1), 64'(e.e1));
            check({e.tag, ".RD2"}, 64'(RD2), 64'(e.e2));
        end
        if (e.mask[1]) check({e.tag, ".ALU_RESULT"}, 64'(ALU_RESULT), 64'(e.ea));
        if (e.mask[2]) check({e.tag, ".RD"}, 64'(RD), 64'(e.er));
        @(negedge clk);
        check({e.tag, ".after_done"}, {62'd0, done, instr_ready}, 64'd1);
    endtask

    localparam logic [DW-1:0] ONES = '1;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        repeat (3) @(negedge clk);
        check("rst.data", {RD1 | RD2 | ALU_RESULT | RD}, 64'd0);
        check("rst.flags", {60'd0, busy, done, illegal, ovf}, 64'd0);
        check("rst.ready", 64'(instr_ready), 64'd1);
        rst_n = 1'b1;

        // Basic arithmetic and memory round trip
        issue("addi2", i_ins(6'h08, 0, 2, 16'd8), 3, 0, 0, M_OPS | M_ALU, 0, 0, 8, 0);
        issue("addi3", i_ins(6'h08, 0, 3, 16'd5), 3, 0, 0, M_OPS | M_ALU, 0, 0, 5, 0);
        issue("add1",  r_ins(6'h20, 2, 3, 1),     3, 0, 0, M_OPS | M_ALU, 8, 5, 13, 0);
        issue("sw",    i_ins(6'h2B, 2, 1, 16'd4), 3, 0, 0, M_OPS | M_ALU, 8, 13, 12, 0);
        issue("lw",    i_ins(6'h23, 2, 4, 16'd4), 4, 0, 0, M_OPS | M_ALU | M_RD, 8, 0, 12, 13);
        issue("add5",  r_ins(6'h20, 4, 0, 5),     3, 0, 0, M_OPS | M_ALU | M_RD, 13, 0, 13, 13);

        // Remaining ALU ops, including signed compare and sign extension
        issue("sub10", r_ins(6'h22, 2, 3, 10), 3, 0, 0, M_OPS | M_ALU, 8, 5, 3, 0);
        issue("and11", r_ins(6'h24, 1, 2, 11), 3, 0, 0, M_OPS | M_ALU, 13, 8, 8, 0);
        issue("or12",  r_ins(6'h25, 2, 3, 12), 3, 0, 0, M_OPS | M_ALU, 8, 5, 13, 0);
        issue("slt_t", r_ins(6'h2A, 3, 2, 13), 3, 0, 0, M_ALU, 0, 0, 1, 0);
        issue("slt_f", r_ins(6'h2A, 2, 3, 13), 3, 0, 0, M_ALU, 0, 0, 0, 0);
        issue("addi9", i_ins(6'h08, 0, 9, 16'hFFFF), 3, 0, 0, M_ALU, 0, 0, ONES, 0);
        issue("slt_n", r_ins(6'h2A, 9, 0, 14), 3, 0, 0, M_OPS | M_ALU, ONES, 0, 1, 0);
        issue("sub15", r_ins(6'h22, 0, 2, 15), 3, 0, 0, M_ALU, 0, 0, DW'(-8), 0);

        // instr_valid held high through busy must not start a second instruction
        issue("lw_nz", i_ins(6'h23, 2, 4, 16'd4), 4, 0, 0, M_OPS | M_RD, 8, 13, 0, 13, 1'b1);
        issue("rb2",   r_ins(6'h20, 2, 0, 0), 3, 0, 0, M_OPS | M_ALU, 8, 0, 8, 0);

        // Illegal opcode and funct: done+illegal at cycle 1, no register write
        issue("ill_op", {6'h3F, 5'd0, 5'd2, 16'd99}, 1, 1, 0, 3'b000, 0, 0, 0, 0, 1'b1);
        issue("ill_fn", r_ins(6'h21, 2, 3, 2), 1, 1, 0, 3'b000, 0, 0, 0, 0);
        issue("rb2b",   r_ins(6'h20, 2, 0, 16), 3, 0, 0, M_OPS | M_ALU, 8, 0, 8, 0);
        issue("zero",   r_ins(6'h20, 0, 0, 17), 3, 0, 0, M_OPS | M_ALU, 0, 0, 0, 0);

        // Address wrap: 1036 = 4*256 + 12 aliases word 3
        issue("lw_wrap", i_ins(6'h23, 0, 18, 16'd1036), 4, 0, 0, M_ALU | M_RD, 0, 0, 1036, 13);

        // Signed overflow: trapped with the macro, wrapped without
        issue("addi6",  i_ins(6'h08, 0, 6, 16'h7FFF), 3, 0, 0, M_ALU, 0, 0, 'h7FFF, 0);
        issue("add7",   r_ins(6'h20, 6, 6, 7), 3, 0, TRAP, M_OPS | M_ALU, 'h7FFF, 'h7FFF, 'hFFFE, 0);
        issue("rb7",    r_ins(6'h20, 7, 0, 0), 3, 0, 0, M_OPS, TRAP ? DW'(0) : DW'('hFFFE), 0, 0, 0);
        issue("addi17", i_ins(6'h08, 6, 17, 16'd1), 3, 0, TRAP, M_OPS | M_ALU, 'h7FFF, 0, 'h8000, 0);
        issue("rb17",   r_ins(6'h20, 17, 0, 0), 3, 0, 0, M_OPS, TRAP ? DW'(0) : DW'('h8000), 0, 0, 0);
        issue("sub19",  r_ins(6'h22, 15, 6, 19), 3, 0, TRAP, M_OPS | M_ALU, DW'(-8), 'h7FFF, DW'(-32775), 0);

        // Reset asserted during EXEC of add $8,$2,$3 aborts it
        @(negedge clk);
        instruction = r_ins(6'h20, 2, 3, 8);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("abort.busy", {62'd0, busy, instr_ready}, 64'd2);
        @(negedge clk);
        check("abort.exec_done", 64'(done), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.rst_flags", {61'd0, done, ALU_RESULT == '0, busy}, 64'd2);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.ready", {62'd0, instr_ready, done}, 64'd2);
        repeat (3) begin
            @(negedge clk);
            check("abort.no_done", 64'(done), 64'd0);
        end
        issue("rb8",   r_ins(6'h20, 8, 2, 0), 3, 0, 0, M_OPS | M_ALU, 0, 0, 0, 0);
        issue("lw_rt", i_ins(6'h23, 0, 4, 16'd12), 4, 0, 0, M_OPS | M_ALU | M_RD, 0, 0, 12, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
